// File: rtl/bc_polinomio.sv
`default_nettype none
// ============================================================================
// Module   : bc_polinomio
// Purpose  : Control block and datapath registers that evaluate
//            Resultado = A*X*X + B*X + C (mod 2^W) in Horner order
//            ((A*X)+B)*X + C, using one shared shift-add multiplier and one
//            shared adder. Operands are captured on the start edge, so the
//            inputs may change freely while the computation runs.
// Ports    : ck        - clock, all state changes on the rising edge
//            rst       - asynchronous active-high reset
//            inicio    - start request, only looked at in IDLE
//            pronto    - result acknowledge, only looked at in DONE
//            X,A,B,C   - polynomial variable and coefficients (W bits)
//            Resultado - registered result, changes only on completion
//            LED       - done flag, high only in DONE
//            ocupado   - busy flag, high in every state but IDLE and DONE
// Revision : 1.0 - initial release
// ============================================================================
module bc_polinomio #(
    parameter int W  = 16,
    parameter int CW = 5
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         inicio,
    input  logic         pronto,
    input  logic [W-1:0] X,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    output logic [W-1:0] Resultado,
    output logic         LED,
    output logic         ocupado
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        ADD1 = 3'd2,
        MUL2 = 3'd3,
        ADD2 = 3'd4,
        DONE = 3'd5
    } state_t;

    // Last iteration index of a multiply: W partial-product steps, 0..W-1.
    localparam logic [CW-1:0] c_last_cnt = CW'(W - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    state_t        r_state;
    logic [W-1:0]  r_xr;
    logic [W-1:0]  r_br;
    logic [W-1:0]  r_cr;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_p;     // partial product
    logic [W-1:0]  r_m;     // multiplicand, shifted left each step
    logic [W-1:0]  r_q;     // multiplier, shifted right each step
    logic [CW-1:0] r_cnt;

    logic [W-1:0]  w_p_next;
    logic [W-1:0]  w_sum;
    logic          w_last;
    logic          w_in_mul;

    // One multiply step: conditionally accumulate the shifted multiplicand.
    // On the last step this value is the full (truncated) product.
    assign w_p_next = r_q[0] ? (r_p + r_m) : r_p;

    // Single adder shared by both add states: acc+B in ADD1, acc+C in ADD2.
    assign w_sum    = r_acc + ((r_state == ADD2) ? r_cr : r_br);

    assign w_last   = (r_cnt == c_last_cnt);
    assign w_in_mul = (r_state == MUL1) || (r_state == MUL2);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_xr      <= '0;
            r_br      <= '0;
            r_cr      <= '0;
            r_acc     <= '0;
            r_p       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            Resultado <= '0;
            LED       <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            if (w_in_mul) begin
                // Both multiplies always run the full W steps, giving a fixed
                // latency regardless of operand values.
                r_p   <= w_p_next;
                r_m   <= r_m << 1;
                r_q   <= r_q >> 1;
                r_cnt <= r_cnt + c_cnt_one;
                if (w_last) begin
                    r_acc   <= w_p_next;
                    r_state <= (r_state == MUL1) ? ADD1 : ADD2;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (inicio) begin
                            r_xr    <= X;
                            r_br    <= B;
                            r_cr    <= C;
                            r_acc   <= A;
                            r_p     <= '0;
                            r_m     <= A;
                            r_q     <= X;
                            r_cnt   <= '0;
                            ocupado <= 1'b1;
                            r_state <= MUL1;
                        end
                    end
                    ADD1: begin
                        // (A*X)+B becomes the multiplicand of the second pass.
                        r_acc   <= w_sum;
                        r_p     <= '0;
                        r_m     <= w_sum;
                        r_q     <= r_xr;
                        r_cnt   <= '0;
                        r_state <= MUL2;
                    end
                    ADD2: begin
                        Resultado <= w_sum;
                        LED       <= 1'b1;
                        ocupado   <= 1'b0;
                        r_state   <= DONE;
                    end
                    DONE: begin
                        // pronto wins over a simultaneous inicio: the new run
                        // can only start from IDLE on a later edge.
                        if (pronto) begin
                            LED     <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bc_polinomio.sv
`default_nettype none
// ============================================================================
// Module   : tb_bc_polinomio
// Purpose  : Self-checking bench for bc_polinomio (W=16). Expected results
//            come from a direct-form polynomial model and are queued when a
//            run is started, then popped when LED rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bc_polinomio;

    localparam int W       = 16;
    localparam int CW      = 5;
    localparam int LATENCY = 2 * W + 2;

    logic         ck;
    logic         rst;
    logic         inicio;
    logic         pronto;
    logic [W-1:0] X;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [W-1:0] Resultado;
    logic         LED;
    logic         ocupado;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] r1;

    bc_polinomio #(.W(W), .CW(CW)) dut (
        .ck        (ck),
        .rst       (rst),
        .inicio    (inicio),
        .pronto    (pronto),
        .X         (X),
        .A         (A),
        .B         (B),
        .C         (C),
        .Resultado (Resultado),
        .LED       (LED),
        .ocupado   (ocupado)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [W-1:0] poly(input logic [W-1:0] x, a, b, c);
        logic [63:0] t;
        t = 64'(a) * 64'(x) * 64'(x) + 64'(b) * 64'(x) + 64'(c);
        return t[W-1:0];
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands, raise inicio and queue the expected result.
    task automatic start(input logic [W-1:0] x, a, b, c);
        X = x; A = a; B = b; C = c;
        inicio = 1'b1;
        sb.push_back(poly(x, a, b, c));
    endtask

    // First tick is the capture edge; then count edges until LED rises.
    task automatic run_to_done(input int hold_inicio, input bit scramble);
        int           lat;
        logic [W-1:0] prev;
        logic [W-1:0] exp;
        prev = Resultado;
        tick();
        lat = 0;
        chk("busy_after_capture", ocupado, 1);
        while (LED !== 1'b1 && lat < 100) begin
            inicio = (lat + 1 < hold_inicio);
            if (scramble) begin
                X = 16'($urandom); A = 16'($urandom);
                B = 16'($urandom); C = 16'($urandom);
                pronto = (lat == 3);
            end
            tick();
            lat++;
            if (lat == 20) chk("result_hold_midrun", Resultado, prev);
        end
        chk("latency", lat, LATENCY);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("resultado", Resultado, exp);
        chk("ocupado_in_done", ocupado, 0);
    endtask

    task automatic ack();
        chk("led_before_ack", LED, 1);
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        chk("led_after_ack", LED, 0);
        chk("ocupado_after_ack", ocupado, 0);
    endtask

    initial begin
        rst = 1'b1; inicio = 1'b0; pronto = 1'b0;
        X = '0; A = '0; B = '0; C = '0;
        tick();
        tick();
        chk("reset_resultado", Resultado, 0);
        chk("reset_led", LED, 0);
        chk("reset_ocupado", ocupado, 0);
        #3 rst = 1'b0;
        tick();

        // Basic run, inicio pulsed for two cycles, DONE holds until pronto.
        start(16'd2, 16'd1, 16'd3, 16'd4);
        run_to_done(2, 1'b0);
        tick(); tick(); tick();
        chk("led_holds_in_done", LED, 1);
        chk("resultado_holds_in_done", Resultado, 14);
        ack();

        // Zero variable and unit operands.
        start(16'h0000, 16'd7, 16'd9, 16'h1234);
        run_to_done(1, 1'b0);
        ack();
        start(16'd1, 16'd1, 16'd1, 16'd1);
        run_to_done(1, 1'b0);
        ack();

        // Wrap-around.
        start(16'hFFFF, 16'd1, 16'd0, 16'd0);
        run_to_done(1, 1'b0);
        ack();
        start(16'h0100, 16'd1, 16'd0, 16'd5);
        run_to_done(1, 1'b0);
        ack();

        // Operands churn after capture, inicio held 40 cycles, pronto pulsed in MUL1.
        start(16'h0123, 16'h0045, 16'h0678, 16'h9ABC);
        run_to_done(40, 1'b1);
        r1 = Resultado;
        tick(); tick();
        chk("no_restart_in_done_led", LED, 1);
        chk("no_restart_in_done_busy", ocupado, 0);
        inicio = 1'b0;
        ack();
        tick();
        chk("idle_stays_idle", ocupado, 0);

        // inicio and pronto together in DONE: IDLE only, restart next edge.
        start(16'd3, 16'd2, 16'd5, 16'd7);
        run_to_done(1, 1'b0);
        r1 = Resultado;
        start(16'd10, 16'd20, 16'd30, 16'd40);
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        chk("corner_led_cleared", LED, 0);
        chk("corner_no_restart", ocupado, 0);
        chk("corner_result_held", Resultado, r1);
        run_to_done(3, 1'b0);
        ack();

        // Asynchronous reset in MUL2, between clock edges.
        start(16'd5, 16'd6, 16'd7, 16'd8);
        tick();
        inicio = 1'b0;
        repeat (25) tick();
        chk("busy_in_mul2", ocupado, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_resultado", Resultado, 0);
        chk("async_rst_led", LED, 0);
        chk("async_rst_ocupado", ocupado, 0);
        void'(sb.pop_back());
        #3 rst = 1'b0;
        tick();
        tick();
        chk("after_rst_idle", ocupado, 0);
        chk("after_rst_no_result", LED, 0);

        start(16'h0031, 16'h0102, 16'h0203, 16'h0304);
        run_to_done(1, 1'b0);
        ack();

        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bc_polinomio.md
Name: bc_polinomio

Overview:
- Control block that evaluates Resultado = A*X*X + B*X + C (mod 2^W) on a single shared shift-add multiplier and a single adder.
- Uses Horner order ((A*X)+B)*X + C.
- Sits between the top-level start/acknowledge handshake (inicio/pronto) and the operand/result datapath registers.
- Sequences operand capture, two iterative multiplies, two adds, and the done/acknowledge handshake.

Parameters:
- W, 16, data width of operands, accumulator and result.
- CW, 5, iteration counter width; must satisfy 2^CW > W.

Ports:
- ck  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous active-high reset.
- inicio  input  1  start request; sampled only in IDLE.
- pronto  input  1  result acknowledge; sampled only in DONE.
- X  input  W  polynomial variable.
- A  input  W  quadratic coefficient.
- B  input  W  linear coefficient.
- C  input  W  constant term.
- Resultado  output  W  registered result; holds until the next completion.
- LED  output  1  done flag; high only in DONE.
- ocupado  output  1  high in every state except IDLE and DONE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - Resultado=0, LED=0, ocupado=0.
  - Internal registers xr, br, cr, acc, P, M, Q, cnt all cleared.
  - Reset asserted mid-operation aborts the computation immediately; no partial result reaches Resultado.
- States and transitions:
  - IDLE: inicio=1 at an edge loads xr<=X, br<=B, cr<=C, acc<=A, and enters MUL1 with cnt<=0, P<=0, M<=A, Q<=X. Otherwise stay.
  - MUL1: each edge, if Q[0] then P<=P+M; M<=M<<1; Q<=Q>>1; cnt<=cnt+1. All truncated to W bits. On the edge where cnt==W-1, acc<=final P and state<=ADD1.
  - ADD1: one edge. acc<=acc+br (mod 2^W). Set P<=0, M<=acc+br, Q<=xr, cnt<=0. state<=MUL2.
  - MUL2: identical to MUL1; on cnt==W-1, acc<=final P and state<=ADD2.
  - ADD2: one edge. Resultado<=acc+cr (mod 2^W). LED<=1. state<=DONE.
  - DONE: LED=1. pronto=1 at an edge clears LED and enters IDLE. Otherwise hold.
- Latency:
  - Edge k samples inicio=1 in IDLE.
  - LED rises and Resultado updates at edge k+2W+2 (34 cycles for W=16).
  - Minimum return to IDLE is one further edge after LED rises.
- Handshake and boundary rules:
  - inicio is ignored outside IDLE. Holding inicio high through the whole computation does not restart it.
  - inicio still high on the edge that enters IDLE from DONE is sampled at the next edge and starts a new run.
  - pronto is ignored outside DONE.
  - pronto and inicio both high in DONE: go to IDLE only; no restart on that edge.
  - Operand inputs may change freely after the capture edge; the result uses captured values only.
  - Overflow wraps silently: every product and sum is truncated to W bits, with no carry or flag.
  - X=0: both multiplies take the full W cycles anyway (fixed latency); result = C.
  - Resultado is written only in ADD2 and holds through IDLE and later runs until the next ADD2.

Test Plan:
- Basic run: reset, X=2, A=1, B=3, C=4, pulse inicio for 2 cycles -> LED rises exactly 34 edges after the first sampling edge with Resultado=14 and ocupado=0. LED stays high until pronto=1, then LED=0 on the next edge.
- Zero variable: X=0, A=7, B=9, C=0x1234 -> Resultado=0x1234 with latency 34. Same run with X=1, A=1, B=1, C=1 -> Resultado=3.
- Wrap-around: X=0xFFFF, A=1, B=0, C=0 -> Resultado=0x0001. Then X=0x0100, A=1, B=0, C=5 -> Resultado=0x0005.
- Operand stability: change X/A/B/C every cycle after the capture edge, with inicio held high for 40 cycles -> one computation only, using the captured values. Pulsing pronto during MUL1 has no effect.
- Handshake corner: in DONE assert inicio and pronto together -> IDLE, no restart that edge. Keep inicio high -> new run starts next edge and the previous Resultado holds until the new ADD2.
- Reset mid-operation: assert rst asynchronously between clock edges during MUL2 -> outputs 0 immediately, state IDLE. After release, a fresh run gives the correct result.
